// File: rtl/flex_counter_ctrl_if.sv
// ---------------------------------------------------------------------------
// flex_counter_ctrl_if
//
// Command handshake bundle for flex_counter_ctrl. The sequencing logic that
// issues timing commands is the master, and the controller is the slave.
//
// Signals:
//   cmd_valid   master->slave  command present
//   cmd_ready   slave->master  controller can accept a command
//   cmd_period  master->slave  rollover value for the counter
//   cmd_reps    master->slave  number of rollovers before done
//
// The widths must match the NUM_CNT_BITS / NUM_REP_BITS values of the
// flex_counter_ctrl that the interface is connected to.
// ---------------------------------------------------------------------------
interface flex_counter_ctrl_if #(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_REP_BITS = 8
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [NUM_CNT_BITS-1:0] cmd_period;
    logic [NUM_REP_BITS-1:0] cmd_reps;

    modport master (
        output cmd_valid,
        output cmd_period,
        output cmd_reps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_period,
        input  cmd_reps,
        output cmd_ready
    );
endinterface

// File: rtl/flex_counter_ctrl.sv
// ---------------------------------------------------------------------------
// flex_counter_ctrl
//
// Initiator-side controller for one flex_counter. It accepts a timing
// command (period, repetition count) and drives the counter until it has
// seen the requested number of rollovers. Then it pulses done.
//
// Ports:
//   CLK            system clock, rising edge
//   RST            asynchronous active-high reset
//   cmd            command handshake (flex_counter_ctrl_if.slave):
//                  cmd_valid, cmd_ready, cmd_period, cmd_reps
//   abort          terminate the active command (LOAD/RUN only)
//   count_out      from counter
//   rollover_flag  from counter
//   clear          to counter, synchronous clear
//   count_enable   to counter
//   rollover_val   to counter, last accepted period
//   busy           command in progress (LOAD, RUN)
//   reps_left      rollovers still to be seen
//   done           one-cycle completion pulse
//   err            one-cycle pulse after an illegal command (period or reps 0)
//   chk_fail       sticky counter-consistency failure
//
// Optional feature: define FLEX_COUNTER_CTRL_CHECK_EN to build a shadow
// counter. The shadow counter cross-checks count_out and rollover_flag
// during RUN. When the macro is undefined, chk_fail is tied to 0.
//
// All outputs are either registers or decodes of the registered state.
// ---------------------------------------------------------------------------
module flex_counter_ctrl #(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_REP_BITS = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    flex_counter_ctrl_if.slave      cmd,
    input  logic                    abort,
    input  logic [NUM_CNT_BITS-1:0] count_out,
    input  logic                    rollover_flag,
    output logic                    clear,
    output logic                    count_enable,
    output logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    busy,
    output logic [NUM_REP_BITS-1:0] reps_left,
    output logic                    done,
    output logic                    err,
    output logic                    chk_fail
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } state_t;

    localparam logic [NUM_REP_BITS-1:0] ONE_REP = NUM_REP_BITS'(1);

    state_t                  state_reg;
    state_t                  state_next;
    logic [NUM_CNT_BITS-1:0] rollover_val_reg;
    logic [NUM_REP_BITS-1:0] reps_left_reg;
    logic                    err_reg;

    logic cmd_fire;
    logic cmd_illegal;
    logic accept_legal;
    logic rollover_event;

    // A command can only be taken in IDLE, because cmd_ready is decoded from it.
    assign cmd_fire       = (state_reg == IDLE) && cmd.cmd_valid;
    assign cmd_illegal    = (cmd.cmd_period == '0) || (cmd.cmd_reps == '0);
    assign accept_legal   = cmd_fire && !cmd_illegal;
    // count_enable is high exactly in RUN, so the event is flag-in-RUN.
    // With period 1 the flag stays high, and every RUN cycle after the
    // first one is an event.
    assign rollover_event = (state_reg == RUN) && rollover_flag;

    // ---------------- state register ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept_legal) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = abort ? ABORT : RUN;
            end
            RUN: begin
                // abort takes priority over a coincident rollover event
                if (abort) begin
                    state_next = ABORT;
                end else if (rollover_event && (reps_left_reg == ONE_REP)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            ABORT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rollover_val_reg <= '0;
            reps_left_reg    <= '0;
            err_reg          <= 1'b0;
        end else begin
            err_reg <= cmd_fire && cmd_illegal;

            if (accept_legal) begin
                rollover_val_reg <= cmd.cmd_period;
            end

            if (accept_legal) begin
                reps_left_reg <= cmd.cmd_reps;
            end else if (rollover_event && !abort) begin
                reps_left_reg <= reps_left_reg - ONE_REP;
            end else if (state_reg == ABORT) begin
                // The value is held during ABORT, then cleared as we re-enter IDLE.
                reps_left_reg <= '0;
            end
        end
    end

    // ---------------- output decode ----------------
    assign cmd.cmd_ready  = (state_reg == IDLE);
    assign clear          = (state_reg == LOAD) || (state_reg == ABORT);
    assign count_enable   = (state_reg == RUN);
    assign busy           = (state_reg == LOAD) || (state_reg == RUN);
    assign done           = (state_reg == DONE);
    assign err            = err_reg;
    assign rollover_val   = rollover_val_reg;
    assign reps_left      = reps_left_reg;

`ifdef FLEX_COUNTER_CTRL_CHECK_EN
    // Shadow counter. It follows what a correct flex_counter must show:
    // it is 0 after the LOAD clear, it counts up on each enabled cycle,
    // and it wraps to 1 after reaching rollover_val.
    localparam logic [NUM_CNT_BITS-1:0] ONE_CNT = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] shadow_reg;
    logic                    chk_fail_reg;
    logic                    run_mismatch;

    assign run_mismatch = (state_reg == RUN) &&
                          ((count_out != shadow_reg) ||
                           (rollover_flag != (count_out == rollover_val_reg)));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow_reg   <= '0;
            chk_fail_reg <= 1'b0;
        end else begin
            if (state_reg == LOAD) begin
                shadow_reg <= '0;
            end else if (state_reg == RUN) begin
                shadow_reg <= (shadow_reg == rollover_val_reg) ? ONE_CNT
                                                               : shadow_reg + ONE_CNT;
            end

            if (accept_legal) begin
                chk_fail_reg <= 1'b0;
            end else if (run_mismatch) begin
                chk_fail_reg <= 1'b1;
            end
        end
    end

    assign chk_fail = chk_fail_reg;
`else
    // Without the checker, the counter's count value is not needed.
    logic unused_count_out;
    assign unused_count_out = ^count_out;
    assign chk_fail         = 1'b0;
`endif

endmodule
